mux_nx1_scan: RTL and testbench

Parametrised N-channel, WIDTH-bit registered multiplexer. It is the successor to the fixed 8-bit 13:1 combinational mux. Two operating modes:
- DIRECT: a loaded select value picks the channel.
- SCAN: an internal channel counter steps through channels 0..N-1 every PERIOD enabled cycles.
Used by the game datapath for memory/display channel selection and time-multiplexed display scanning. Output data and the current channel index are registered together, with a one-cycle change strobe.

---
 rtl/mux_nx1_scan_pkg.sv | 14 +
 rtl/mux_nx1_scan_if.sv | 31 +++
 rtl/mux_scan_counter.sv | 67 ++++++
 rtl/mux_nx1_scan.sv | 104 ++++++++++
 tb/tb_mux_nx1_scan.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/mux_nx1_scan_pkg.sv
// mux_nx1_scan_pkg: shared state encodings and mode constants for the
// N-channel registered scan multiplexer.
package mux_nx1_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_nx1_scan_if.sv
// mux_nx1_scan_if: control and data bundle for mux_nx1_scan.
//   enable, mode, load, sel, data_in : driven by the master (user)
//   data_out, chan_out, valid        : driven by the slave (mux)
//   sel_err                          : only present with MUX_SEL_ERR_EN
interface mux_nx1_scan_if #(
  parameter int WIDTH = 8,
  parameter int N     = 13,
  parameter int SELW  = 4
);
  logic                 enable;
  logic                 mode;
  logic                 load;
  logic [SELW-1:0]      sel;
  logic [N*WIDTH-1:0]   data_in;
  logic [WIDTH-1:0]     data_out;
  logic [SELW-1:0]      chan_out;
  logic                 valid;
`ifdef MUX_SEL_ERR_EN
  logic                 sel_err;

  modport master (output enable, mode, load, sel, data_in,
                  input  data_out, chan_out, valid, sel_err);
  modport slave  (input  enable, mode, load, sel, data_in,
                  output data_out, chan_out, valid, sel_err);
`else
  modport master (output enable, mode, load, sel, data_in,
                  input  data_out, chan_out, valid);
  modport slave  (input  enable, mode, load, sel, data_in,
                  output data_out, chan_out, valid);
`endif
endinterface

// File: rtl/mux_scan_counter.sv
// mux_scan_counter: prescaler plus wrapping channel counter.
//   clock, reset : clock and async active-high reset
//   enable       : low holds prescaler and channel
//   scan         : effective mode this cycle is SCAN
//   enter_scan   : first SCAN cycle; clears prescaler, keeps channel
//   load, sel    : load a channel (out-of-range forced to 0 in SCAN)
//   chan         : current channel (registered)
//   chan_next    : channel after this edge
//   step         : a scheduled scan advance happens this edge
module mux_scan_counter #(
  parameter int N      = 13,
  parameter int SELW   = 4,
  parameter int PERIOD = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            enable,
  input  logic            scan,
  input  logic            enter_scan,
  input  logic            load,
  input  logic [SELW-1:0] sel,
  output logic [SELW-1:0] chan,
  output logic [SELW-1:0] chan_next,
  output logic            step
);
  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [PW-1:0] PSC_LAST = PW'(PERIOD - 1);

  logic [PW-1:0]   psc_q, psc_d;
  logic [SELW-1:0] chan_q, chan_d;

  always_comb begin
    psc_d  = psc_q;
    chan_d = chan_q;
    step   = 1'b0;
    if (enable) begin
      if (load) begin
        chan_d = (scan && int'(sel) >= N) ? '0 : sel;
        psc_d  = '0;
      end else if (enter_scan) begin
        psc_d = '0;
      end else if (scan) begin
        if (psc_q == PSC_LAST) begin
          step  = 1'b1;
          psc_d = '0;
          // >= also recovers a channel left out of range by DIRECT mode
          chan_d = (int'(chan_q) >= N - 1) ? '0 : chan_q + 1'b1;
        end else begin
          psc_d = psc_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      psc_q  <= '0;
      chan_q <= '0;
    end else begin
      psc_q  <= psc_d;
      chan_q <= chan_d;
    end
  end

  assign chan      = chan_q;
  assign chan_next = chan_d;
endmodule

// File: rtl/mux_nx1_scan.sv
// mux_nx1_scan: N-channel WIDTH-bit registered multiplexer with DIRECT and
// SCAN modes.
//   clock, reset : clock and async active-high reset
//   bus (slave)  : enable/mode/load/sel/data_in in; data_out/chan_out/valid out
// Optional macro MUX_SEL_ERR_EN adds sticky bus.sel_err, set when a load is
// accepted with sel >= N.
module mux_nx1_scan
  import mux_nx1_scan_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N       = 13,
  parameter int SELW    = 4,
  parameter int PERIOD  = 4,
  parameter int DEFAULT = 0
) (
  input  logic         clock,
  input  logic         reset,
  mux_nx1_scan_if.slave bus
);
  state_e          state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d, data_sel;
  logic            valid_q, valid_d;
  logic            scan, enter_scan, step;
  logic [SELW-1:0] chan, chan_next;

  assign scan       = (bus.mode == MODE_SCAN);
  assign enter_scan = scan && (state_q != ST_SCAN);

  always_comb begin
    state_d = state_q;
    if (bus.enable) begin
      state_d = scan ? ST_SCAN : ST_DIRECT;
    end
  end

  mux_scan_counter #(
    .N      (N),
    .SELW   (SELW),
    .PERIOD (PERIOD)
  ) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .enable     (bus.enable),
    .scan       (scan),
    .enter_scan (enter_scan),
    .load       (bus.load),
    .sel        (bus.sel),
    .chan       (chan),
    .chan_next  (chan_next),
    .step       (step)
  );

  always_comb begin
    data_sel = WIDTH'(DEFAULT);
    for (int unsigned k = 0; k < N; k++) begin
      if (chan_next == SELW'(k)) begin
        data_sel = bus.data_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = 1'b0;
    if (bus.enable) begin
      data_d  = data_sel;
      valid_d = bus.load || (chan_next != chan);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      data_q  <= WIDTH'(DEFAULT);
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_out = data_q;
  assign bus.chan_out = chan;
  assign bus.valid    = valid_q;

`ifdef MUX_SEL_ERR_EN
  logic sel_err_q, sel_err_d;

  always_comb begin
    sel_err_d = sel_err_q;
    if (bus.enable && bus.load && int'(bus.sel) >= N) begin
      sel_err_d = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) sel_err_q <= 1'b0;
    else       sel_err_q <= sel_err_d;
  end

  assign bus.sel_err = sel_err_q;
`endif
endmodule

// File: tb/tb_mux_nx1_scan.sv
// tb_mux_nx1_scan: directed and randomized bench for mux_nx1_scan against an
// integer reference model of the channel/prescaler rules.
module tb_mux_nx1_scan;
  localparam int WIDTH   = 8;
  localparam int N       = 13;
  localparam int SELW    = 4;
  localparam int PERIOD  = 4;
  localparam int DEFAULT = 0;

  logic clock;
  logic reset;

  mux_nx1_scan_if #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) bus ();

  mux_nx1_scan #(
    .WIDTH   (WIDTH),
    .N       (N),
    .SELW    (SELW),
    .PERIOD  (PERIOD),
    .DEFAULT (DEFAULT)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  int m_chan, m_psc, m_state, m_data;
  bit m_valid, m_err, m_in_scan;
  int din [N];

  task automatic model_reset();
    m_chan = 0; m_psc = 0; m_in_scan = 0; m_state = 0;
    m_data = DEFAULT & ((1 << WIDTH) - 1);
    m_valid = 0; m_err = 0;
  endtask

  task automatic model_edge(input bit e, input bit m, input bit l, input int s);
    int nxt;
    if (!e) begin
      m_valid = 0;
      return;
    end
    if (l) begin
      nxt = (m && s >= N) ? 0 : s;
      m_psc = 0;
      if (s >= N) m_err = 1;
    end else if (m && !m_in_scan) begin
      nxt = m_chan;
      m_psc = 0;
    end else if (m && m_psc == PERIOD - 1) begin
      nxt = (m_chan + 1 >= N) ? 0 : m_chan + 1;
      m_psc = 0;
    end else begin
      nxt = m_chan;
      if (m) m_psc = m_psc + 1;
    end
    m_valid = l || (nxt != m_chan);
    m_chan  = nxt;
    m_data  = (nxt < N) ? din[nxt] : (DEFAULT & ((1 << WIDTH) - 1));
    m_in_scan = m;
    m_state = m ? 2 : 1;
  endtask

  task automatic drive_data();
    for (int k = 0; k < N; k++) bus.data_in[k*WIDTH +: WIDTH] = WIDTH'(din[k]);
  endtask

  task automatic compare_all();
    check("chan_out", 32'(bus.chan_out), 32'(m_chan));
    check("data_out", 32'(bus.data_out), 32'(m_data));
    check("valid",    32'(bus.valid),    32'(m_valid));
`ifdef MUX_SEL_ERR_EN
    check("sel_err",  32'(bus.sel_err),  32'(m_err));
`endif
  endtask

  // Apply inputs, take one edge, update model, compare 1 time unit later.
  task automatic cycle(input bit e, input bit m, input bit l, input int s);
    bus.enable = e; bus.mode = m; bus.load = l; bus.sel = SELW'(s);
    drive_data();
    @(posedge clock);
    model_edge(e, m, l, s);
    #1;
    compare_all();
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 0; bus.mode = 0; bus.load = 0; bus.sel = '0;
    for (int k = 0; k < N; k++) din[k] = 'h10 + k;
    drive_data();
    model_reset();
    #1;
    check("rst_chan",  32'(bus.chan_out), 32'd0);
    check("rst_data",  32'(bus.data_out), 32'd0);
    check("rst_valid", 32'(bus.valid),    32'd0);
    @(negedge clock);
    reset = 1'b0;

    // DIRECT load 5
    cycle(1, 0, 1, 5);
    check("load5_chan",  32'(bus.chan_out), 32'd5);
    check("load5_data",  32'(bus.data_out), 32'h15);
    check("load5_valid", 32'(bus.valid),    32'd1);
    cycle(1, 0, 0, 0);
    check("load5_valid_drop", 32'(bus.valid), 32'd0);

    // DIRECT out-of-range load
    cycle(1, 0, 1, 14);
    check("load14_chan", 32'(bus.chan_out), 32'd14);
    check("load14_data", 32'(bus.data_out), 32'h00);
    cycle(1, 0, 1, 3);
`ifdef MUX_SEL_ERR_EN
    check("sel_err_sticky", 32'(bus.sel_err), 32'd1);
`endif

    // SCAN from channel 11: 11,12,0,1 each held PERIOD cycles
    cycle(1, 1, 1, 11);
    for (int i = 0; i < 15; i++) cycle(1, 1, 0, 0);
    check("scan_at_1", 32'(bus.chan_out), 32'd1);
    // load coinciding with scheduled step
    cycle(1, 1, 1, 7);
    check("load_wins", 32'(bus.chan_out), 32'd7);
    for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0);
    check("hold7", 32'(bus.chan_out), 32'd7);
    cycle(1, 1, 0, 0);
    check("step8", 32'(bus.chan_out), 32'd8);

    // freeze mid-scan
    cycle(1, 1, 0, 0);
    for (int i = 0; i < 10; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, 1, 0, 0);

    // asynchronous reset between edges
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check("arst_chan",  32'(bus.chan_out), 32'd0);
    check("arst_data",  32'(bus.data_out), 32'd0);
    check("arst_valid", 32'(bus.valid),    32'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0);

    // randomized traffic
    begin
      bit rm;
      rm = 0;
      for (int i = 0; i < 400; i++) begin
        for (int k = 0; k < N; k++) din[k] = int'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0) rm = ~rm;
        cycle(bit'($urandom_range(0, 99) < 85), rm,
              bit'($urandom_range(0, 99) < 15), int'($urandom_range(0, 15)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
